// File: rtl/irq_pkg.sv
// Shared constants, slot state encoding and priority helper for the interrupt controller.
package irq_pkg;

  localparam int NSRC = 6;

  localparam logic [4:0] IRQ_PEND     = 5'h00;
  localparam logic [4:0] IRQ_MASK     = 5'h04;
  localparam logic [4:0] IRQ_MODE     = 5'h08;
  localparam logic [4:0] IRQ_CLAIM    = 5'h0C;
  localparam logic [4:0] IRQ_COMPLETE = 5'h10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SERV = 2'd2
  } slot_state_t;

  // Source ID (index+1) of the lowest set bit; 0 when the vector is empty.
  function automatic logic [2:0] prio_id(input logic [NSRC-1:0] v);
    prio_id = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) prio_id = 3'(i + 1);
    end
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Device-bus port of the interrupt controller; rd is combinational on the slave side.
interface irq_ctrl_if;
  logic        sel;
  logic [4:0]  addr;
  logic [31:0] wd;
  logic        we;
  logic        re;
  logic [31:0] rd;

  modport master (output sel, addr, wd, we, re, input rd);
  modport slave  (input sel, addr, wd, we, re, output rd);
endinterface

// File: rtl/irq_slot.sv
// Per-source IDLE/PEND/SERV tracker with a re-pend flag; one-cycle update, no backpressure.
module irq_slot
  import irq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic trig,
  input  logic level_mode,
  input  logic src,
  input  logic claim_hit,
  input  logic complete_hit,
  output logic is_pend,
  output logic is_serv
);

  slot_state_t state;
  logic        repend;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      repend <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trig) state <= ST_PEND;
        end
        ST_PEND: begin
          // A claim beats a same-cycle level drop; an edge arriving with the claim is kept.
          if (claim_hit) begin
            state <= ST_SERV;
            if (trig && !level_mode) repend <= 1'b1;
          end else if (level_mode && !src) begin
            state <= ST_IDLE;
          end
        end
        ST_SERV: begin
          if (complete_hit) begin
            state  <= (repend || (level_mode && trig)) ? ST_PEND : ST_IDLE;
            repend <= 1'b0;
          end else if (trig && !level_mode) begin
            repend <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign is_pend = (state == ST_PEND);
  assign is_serv = (state == ST_SERV);

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: mask/mode registers, trigger detect, claim/complete decode.
// Pending reaches hwint one cycle after the trigger; rd and CLAIM ID are combinational.
module irq_ctrl
  import irq_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  irq_ctrl_if.slave       bus,
  input  logic [NSRC-1:0] src,
  output logic [NSRC-1:0] hwint
);

  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] trig;
  logic [NSRC-1:0] is_pend;
  logic [NSRC-1:0] is_serv;
  logic [NSRC-1:0] masked;
  logic [NSRC-1:0] claim_hit;
  logic [NSRC-1:0] complete_hit;
  logic [4:0]      off;
  logic [2:0]      claim_id;
  logic            claim_fire;
  logic            complete_fire;
  logic            reg_wr;
  logic            unused_bus_bits;

  assign off             = {bus.addr[4:2], 2'b00};
  assign unused_bus_bits = ^{bus.addr[1:0], bus.wd[31:NSRC]};

  assign trig     = (mode & src & ~src_q) | (~mode & src);
  assign masked   = is_pend & mask;
  assign hwint    = masked;
  assign claim_id = prio_id(masked);

  // An empty claim read must not disturb any slot.
  assign claim_fire    = bus.sel && bus.re && (off == IRQ_CLAIM) && (claim_id != 3'd0);
  assign complete_fire = bus.sel && bus.we && (off == IRQ_COMPLETE);
  assign reg_wr        = bus.sel && bus.we;

  always_comb begin
    claim_hit    = '0;
    complete_hit = '0;
    for (int i = 0; i < NSRC; i++) begin
      claim_hit[i]    = claim_fire && (claim_id == 3'(i + 1));
      complete_hit[i] = complete_fire && (bus.wd[2:0] == 3'(i + 1)) && is_serv[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mask  <= '0;
      mode  <= '0;
      src_q <= '0;
    end else begin
      src_q <= src;
      if (reg_wr && (off == IRQ_MASK)) mask <= bus.wd[NSRC-1:0];
      if (reg_wr && (off == IRQ_MODE)) mode <= bus.wd[NSRC-1:0];
    end
  end

  always_comb begin
    bus.rd = '0;
    case (off)
      IRQ_PEND:  bus.rd[NSRC-1:0] = is_pend;
      IRQ_MASK:  bus.rd[NSRC-1:0] = mask;
      IRQ_MODE:  bus.rd[NSRC-1:0] = mode;
      IRQ_CLAIM: bus.rd[2:0]      = claim_id;
      default:   bus.rd           = '0;
    endcase
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_slot
    irq_slot u_slot (
      .clk          (clk),
      .reset        (reset),
      .trig         (trig[g]),
      .level_mode   (!mode[g]),
      .src          (src[g]),
      .claim_hit    (claim_hit[g]),
      .complete_hit (complete_hit[g]),
      .is_pend      (is_pend[g]),
      .is_serv      (is_serv[g])
    );
  end

endmodule
